// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, sizes and sigma functions for the message schedule
// and the compression round engine.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int BLOCK_WORDS = 16;
  localparam int ROUNDS      = 64;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32'd32 - n));
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 32'd7) ^ rotr(x, 32'd18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 32'd17) ^ rotr(x, 32'd19) ^ (x >> 10);
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 32'd2) ^ rotr(x, 32'd13) ^ rotr(x, 32'd22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 32'd6) ^ rotr(x, 32'd11) ^ rotr(x, 32'd25);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational schedule expansion: W[t] from W[t-16], W[t-15], W[t-7], W[t-2].
module sha256_w_expand
  import sha256_pkg::*;
(
  input  word_t w_m16,
  input  word_t w_m15,
  input  word_t w_m7,
  input  word_t w_m2,
  output word_t w_new
);

  // Additions wrap modulo 2^32 because every operand and the result are 32 bits.
  assign w_new = small_sigma1(w_m2) + w_m7 + small_sigma0(w_m15) + w_m16;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 16-word block, then streams W0..W(NUM_ROUNDS-1)
// from a 16-word sliding window with valid/ready on both sides.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] blk_word,
  input  logic        blk_valid,
  output logic        blk_ready,
  output logic [31:0] w_out,
  output logic [5:0]  w_index,
  output logic        w_valid,
  input  logic        w_ready,
  output logic        w_last,
  output logic        busy
);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  localparam logic [3:0] CNT_LAST = 4'(BLOCK_WORDS - 1);
  localparam logic [5:0] T_LAST   = 6'(NUM_ROUNDS - 1);

  logic [0:0] state_r;
  logic [3:0] cnt_r;
  logic [5:0] t_r;
  word_t      window_r [BLOCK_WORDS];

  logic  load_fire_s;
  logic  emit_fire_s;
  logic  emit_s;
  word_t w_new_s;

  // Outputs are pure state decodes; gating with rst keeps them quiet while resetting.
  assign emit_s    = (state_r == ST_EMIT) & ~rst;
  assign blk_ready = (state_r == ST_LOAD) & ~rst;
  assign w_valid   = emit_s;
  assign busy      = emit_s;
  assign w_last    = emit_s & (t_r == T_LAST);
  assign w_index   = t_r;
  assign w_out     = window_r[0];

  // Handshake qualifiers for both ports.
  always_comb begin
    load_fire_s = 1'b0;
    emit_fire_s = 1'b0;
    if (blk_valid && blk_ready) begin
      load_fire_s = 1'b1;
    end else begin
      load_fire_s = 1'b0;
    end
    if (w_valid && w_ready) begin
      emit_fire_s = 1'b1;
    end else begin
      emit_fire_s = 1'b0;
    end
  end

  sha256_w_expand u_expand (
    .w_m16 (window_r[0]),
    .w_m15 (window_r[1]),
    .w_m7  (window_r[9]),
    .w_m2  (window_r[14]),
    .w_new (w_new_s)
  );

  // Control FSM: load counter, round index and LOAD/EMIT state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOAD;
      cnt_r   <= 4'd0;
      t_r     <= 6'd0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (load_fire_s) begin
            if (cnt_r == CNT_LAST) begin
              state_r <= ST_EMIT;
              cnt_r   <= 4'd0;
              t_r     <= 6'd0;
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
        end
        ST_EMIT: begin
          if (emit_fire_s) begin
            // Explicit return to t=0 so shorter round counts still leave w_index at 0.
            if (t_r == T_LAST) begin
              state_r <= ST_LOAD;
              cnt_r   <= 4'd0;
              t_r     <= 6'd0;
            end else begin
              t_r <= t_r + 6'd1;
            end
          end
        end
        default: begin
          state_r <= ST_LOAD;
          cnt_r   <= 4'd0;
          t_r     <= 6'd0;
        end
      endcase
    end
  end

  // Window datapath: indexed fill during LOAD, shift-and-append during EMIT.
  always_ff @(posedge clk) begin
    if (load_fire_s) begin
      window_r[cnt_r] <= blk_word;
    end else if (emit_fire_s) begin
      for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
        window_r[i] <= window_r[i+1];
      end
      window_r[BLOCK_WORDS-1] <= w_new_s;
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule with an independent schedule model
// feeding a scoreboard queue of expected (index, word) pairs.
module tb_sha256_msg_schedule;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] blk_word = 32'd0;
  logic        blk_valid = 1'b0;
  logic        blk_ready;
  logic [31:0] w_out;
  logic [5:0]  w_index;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic        w_last;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  exp_t        exp_q[$];
  logic [31:0] blk_q [16];
  logic [31:0] got_w [64];
  logic [31:0] ref_w [64];

  sha256_msg_schedule #(.NUM_ROUNDS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_word  (blk_word),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .w_out     (w_out),
    .w_index   (w_index),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_last    (w_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return m_rotr(x, 7) ^ m_rotr(x, 18) ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return m_rotr(x, 17) ^ m_rotr(x, 19) ^ {10'b0000000000, x[31:10]};
  endfunction

  // Full 64-word schedule of blk_q, pushed as the expected output stream.
  task automatic push_expected();
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk_q[t];
      else        w[t] = m_s1(w[t-2]) + w[t-7] + m_s0(w[t-15]) + w[t-16];
      e.idx = 6'(t);
      e.w   = w[t];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    blk_valid = 1'b0;
    w_ready = 1'b0;
    tick();
    check("rst_w_valid", {31'd0, w_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_blk_ready", {31'd0, blk_ready}, 32'd0);
    check("rst_w_last", {31'd0, w_last}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_w_valid", {31'd0, w_valid}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_w_index", {26'd0, w_index}, 32'd0);
    check("post_rst_blk_ready", {31'd0, blk_ready}, 32'd1);
    exp_q.delete();
  endtask

  task automatic load_words(input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        blk_valid = 1'b0;
        tick();
      end
      blk_valid = 1'b1;
      blk_word  = blk_q[i];
      check("load_blk_ready", {31'd0, blk_ready}, 32'd1);
      if (i == 15) push_expected();
      tick();
    end
    blk_valid = 1'b0;
    if (n == 16) begin
      check("latency_w_valid", {31'd0, w_valid}, 32'd1);
      check("latency_busy", {31'd0, busy}, 32'd1);
    end
  endtask

  // Drains the output stream; returns early once w_index reaches stop_at.
  task automatic emit(input int wr_pct, input bit hold_junk, input int stop_at);
    int   n;
    bit   held;
    exp_t e;
    logic [31:0] held_w;
    logic [5:0]  held_i;
    n = 0;
    held = 1'b0;
    held_w = 32'd0;
    held_i = 6'd0;
    for (int cyc = 0; cyc < 2000 && n < 64; cyc++) begin
      w_ready   = ($urandom_range(99) < wr_pct);
      blk_valid = hold_junk;
      blk_word  = hold_junk ? 32'hDEADBEEF : 32'd0;
      #1;
      if (stop_at >= 0 && w_valid === 1'b1 && int'(w_index) == stop_at) begin
        w_ready = 1'b0;
        blk_valid = 1'b0;
        return;
      end
      check("emit_blk_ready", {31'd0, blk_ready}, 32'd0);
      check("emit_w_valid", {31'd0, w_valid}, 32'd1);
      if (held) begin
        check("stall_w_out", w_out, held_w);
        check("stall_w_index", {26'd0, w_index}, {26'd0, held_i});
      end
      if (w_ready) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("w_out[%0d]", e.idx), w_out, e.w);
          check("w_index", {26'd0, w_index}, {26'd0, e.idx});
          check("w_last", {31'd0, w_last}, {31'd0, (e.idx == 6'd63)});
          got_w[e.idx] = w_out;
        end
        n++;
        held = 1'b0;
      end else begin
        held   = 1'b1;
        held_w = w_out;
        held_i = w_index;
      end
      tick();
    end
    w_ready = 1'b0;
    check("emit_count", n, 32'd64);
    check("end_blk_ready", {31'd0, blk_ready}, 32'd1);
    check("end_w_valid", {31'd0, w_valid}, 32'd0);
  endtask

  initial begin
    do_reset();

    // "abc" block, no stalls.
    for (int i = 0; i < 16; i++) blk_q[i] = 32'd0;
    blk_q[0]  = 32'h61626380;
    blk_q[15] = 32'h00000018;
    load_words(16, 0);
    emit(100, 1'b0, -1);
    check("abc_w16", got_w[16], 32'h61626380);
    check("abc_w17", got_w[17], 32'h000F0000);
    for (int i = 0; i < 64; i++) ref_w[i] = got_w[i];

    // Same block with input gaps and 50% backpressure.
    for (int i = 0; i < 64; i++) got_w[i] = 32'd0;
    load_words(16, 40);
    emit(50, 1'b0, -1);
    for (int i = 0; i < 64; i++) check($sformatf("stall_vs_nostall[%0d]", i), got_w[i], ref_w[i]);

    // Junk word held on blk_valid during EMIT, then an all-ones block.
    for (int i = 0; i < 16; i++) blk_q[i] = $urandom;
    load_words(16, 0);
    emit(100, 1'b1, -1);
    for (int i = 0; i < 16; i++) blk_q[i] = 32'hFFFFFFFF;
    load_words(16, 0);
    emit(100, 1'b0, -1);

    // Reset after 9 words, then mid-emit at w_index=30, then a clean block.
    for (int i = 0; i < 16; i++) blk_q[i] = $urandom;
    load_words(9, 0);
    do_reset();
    for (int i = 0; i < 16; i++) blk_q[i] = $urandom;
    load_words(16, 0);
    emit(100, 1'b0, 30);
    do_reset();
    for (int i = 0; i < 16; i++) blk_q[i] = $urandom;
    load_words(16, 20);
    emit(70, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Producer side of the SHA-256 round datapath: accepts one 512-bit message block as 16 big-endian 32-bit words and emits the 64 schedule words W0..W63 to the compression-round engine.
- The compression engine consumes these words one per round alongside its big-sigma functions.
- Uses a 16-word sliding window with the small-sigma expansion. Input and output each use a valid/ready handshake.

Parameters:
- NUM_ROUNDS, 64, number of W words emitted per block; legal range 16..64, with 64 used in the design.
- BLOCK_WORDS, 16, words per input block; fixed by SHA-256 and not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- blk_word  input  32  message word, W0 first, big-endian word order.
- blk_valid  input  1  blk_word is valid.
- blk_ready  output  1  block is accepting a message word.
- w_out  output  32  current schedule word W_t.
- w_index  output  6  round index t of w_out.
- w_valid  output  1  w_out and w_index are valid.
- w_ready  input  1  consumer accepts w_out.
- w_last  output  1  high with w_valid when t = NUM_ROUNDS-1.
- busy  output  1  high in the EMIT state.

Behaviour:
- States:
  - LOAD (the reset state): collects BLOCK_WORDS words.
  - EMIT: streams NUM_ROUNDS words.
- Reset:
  - On any rising edge with rst=1: state<=LOAD, load counter<=0, t<=0, window contents don't-care.
  - All outputs are registered or state-decoded. While in reset and on the cycle after: w_valid=0, w_last=0, busy=0, w_index=0.
  - blk_ready=0 while rst=1, and 1 in the first cycle after rst falls.
  - Reset mid-block or mid-emit discards all data; no partial word is emitted afterwards.
- LOAD:
  - blk_ready=1.
  - Each edge with blk_valid&blk_ready writes blk_word into window[cnt] and increments cnt.
  - On acceptance of the 16th word: state<=EMIT, t<=0. w_valid=1 in the very next cycle with w_out=W0.
  - Latency from the last input word to W0 is one cycle.
- EMIT:
  - blk_ready=0; blk_valid is ignored.
  - w_out=window[0], w_index=t, busy=1.
  - On each w_valid&w_ready edge:
    - window shifts down one word (window[i]<=window[i+1]).
    - window[15]<=sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^32.
    - t<=t+1.
  - Words appended for t>=NUM_ROUNDS-16 are unobservable; no special casing.
  - w_ready=0 holds w_out, w_index and w_valid stable (no drop, no duplicate).
- Small-sigma functions:
  - sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - SHR is a logical shift, zero-filled.
- Arithmetic: 32-bit modular add; carries beyond bit 31 are discarded.
- End of block:
  - On the handshake of t=NUM_ROUNDS-1 (w_last=1): state<=LOAD, cnt<=0.
  - blk_ready=1 next cycle, so back-to-back blocks have exactly one bubble cycle between W63 and the first accepted word of the next block.
  - Words offered during EMIT are not accepted and must be held by the upstream.
- Throughput: one W word per cycle while w_ready=1; one input word per cycle in LOAD.

Decomposition:
- Shared package sha256_pkg holds:
  - word typedef (32-bit).
  - constants BLOCK_WORDS=16 and ROUNDS=64.
  - pure functions rotr, small_sigma0, small_sigma1, plus big_sigma0/big_sigma1 for reuse by the round engine.
- One natural sub-module, sha256_w_expand: combinational 4-input expansion producing window[15]'s next value, kept separate for unit-level checking.

Test Plan:
- "abc" block: W0=0x61626380, W1..W14=0, W15=0x00000018.
  - Expect W0..W15 echoed, W16=0x61626380, W17=0x000F0000.
  - W18..W63 must match the golden C model.
  - w_last only at w_index=63.
- Latency: 16 words on consecutive cycles, w_ready=1.
  - w_valid rises exactly one cycle after the 16th handshake.
  - 64 outputs arrive on 64 consecutive cycles; blk_ready=1 the cycle after W63.
- Backpressure: random w_ready (50%) and random gaps in blk_valid.
  - Output sequence identical to the no-stall run; w_out stable while w_valid&!w_ready.
- blk_valid held high during EMIT with word 0xDEADBEEF: blk_ready=0 throughout and the word is not consumed.
  - The second block (0xFFFFFFFF x16) is accepted afterwards and matches the model, exercising the add carry-out discard.
- rst asserted after 9 input words, then again at w_index=30.
  - Each time: w_valid=0, busy=0, blk_ready=0 during reset.
  - A fresh full block then produces a model-exact W0..W63.
